// File: rtl/data_mem_param.sv
// Parameterised single-port data memory with a post-reset zeroing sweep,
// registered write-first reads, address-range checking and a low-word window.
module data_mem_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W,
    parameter int WIN    = 4
) (
    input  logic                    clk,
    input  logic                    ResetN,
    input  logic [ADDR_W-1:0]       DataAddress,
    input  logic                    ReadMem,
    input  logic                    WriteMem,
    input  logic [DATA_W-1:0]       DataIn,
    output logic [DATA_W-1:0]       DataOut,
    output logic                    ReadValid,
    output logic                    Busy,
    output logic                    AddrErr,
    output logic [WIN*DATA_W-1:0]   WinData
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              ready;
    logic              wr_en;
    logic              rd_en;
    logic              req_err;

    // A fully populated address space can never be out of range.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_full
            assign in_range = 1'b1;
        end else begin : g_partial
            assign in_range = ({1'b0, DataAddress} < (ADDR_W + 1)'(DEPTH));
        end
    endgenerate

    assign idx     = DataAddress[IDX_W-1:0];
    assign ready   = (state == ST_READY);
    assign wr_en   = ready & WriteMem & in_range;
    assign rd_en   = ready & ReadMem;
    assign req_err = ready & (ReadMem | WriteMem) & ~in_range;
    assign Busy    = ~ResetN | ~ready;

    // NOTE: the array has no reset branch; zeroing is done by the sweep so the
    // storage can map onto plain RAM cells instead of DEPTH*DATA_W flops.
    always_ff @(posedge clk) begin
        if (ResetN) begin
            if (!ready) begin
                mem[clr_ptr] <= '0;
            end else if (wr_en) begin
                mem[idx] <= DataIn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!ResetN) begin
            state     <= ST_CLEAR;
            clr_ptr   <= '0;
            DataOut   <= '0;
            ReadValid <= 1'b0;
            AddrErr   <= 1'b0;
            WinData   <= '0;
        end else begin
            ReadValid <= rd_en;
            AddrErr   <= req_err;

            if (!ready) begin
                if (clr_ptr == LAST_IDX) begin
                    state   <= ST_READY;
                    clr_ptr <= '0;
                end else begin
                    clr_ptr <= clr_ptr + 1'b1;
                end
            end

            // NOTE: a simultaneous write bypasses the array so the read sees the new word.
            if (rd_en) begin
                if (!in_range) begin
                    DataOut <= '0;
                end else if (WriteMem) begin
                    DataOut <= DataIn;
                end else begin
                    DataOut <= mem[idx];
                end
            end

            for (int k = 0; k < WIN; k++) begin
                if (!ready && clr_ptr == IDX_W'(k)) begin
                    WinData[k*DATA_W +: DATA_W] <= '0;
                end else if (wr_en && idx == IDX_W'(k)) begin
                    WinData[k*DATA_W +: DATA_W] <= DataIn;
                end
            end
        end
    end

endmodule

// File: doc/data_mem_param.md
DATA_MEM_PARAM -- requirements
Module: data_mem_param

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W, number of implemented words; SHALL satisfy 1 <= DEPTH <= 2**ADDR_W.
REQ-004 Parameter WIN, default 4, number of low words mirrored to WinData; SHALL satisfy 1 <= WIN <= DEPTH.
REQ-005 clk  input  1  sole clock; all state changes on posedge.
REQ-006 ResetN  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-007 DataAddress  input  ADDR_W  word address for read and write.
REQ-008 ReadMem  input  1  read request, sampled on posedge.
REQ-009 WriteMem  input  1  write request, sampled on posedge.
REQ-010 DataIn  input  DATA_W  write data.
REQ-011 DataOut  output  DATA_W  registered read data.
REQ-012 ReadValid  output  1  one-cycle pulse, DataOut updated this cycle.
REQ-013 Busy  output  1  high during reset and the clear sweep; requests ignored.
REQ-014 AddrErr  output  1  one-cycle pulse, previous request addressed DataAddress >= DEPTH.
REQ-015 WinData  output  WIN*DATA_W  registered copy of words 0..WIN-1, word k at bits [k*DATA_W +: DATA_W].

Function
REQ-016 The block SHALL have two states: CLEAR and READY.
REQ-017 CLEAR: one word per cycle written to zero, pointer ascending 0..DEPTH-1; Busy=1.
REQ-018 CLEAR->READY on the edge that zeroes word DEPTH-1; the sweep takes exactly DEPTH cycles after ResetN rises, and Busy falls on that edge.
REQ-019 In CLEAR, ReadMem and WriteMem SHALL be ignored: no write, no ReadValid, no AddrErr.
REQ-020 In READY, WriteMem=1 with DataAddress < DEPTH SHALL store DataIn at that address on the edge.
REQ-021 In READY, ReadMem=1 with DataAddress < DEPTH SHALL load DataOut with mem[DataAddress] on the edge, with ReadValid=1 for the following cycle; read latency is 1 cycle.
REQ-022 ReadMem and WriteMem both 1 on the same edge (same address) SHALL be write-first: DataOut gets DataIn and memory gets DataIn.
REQ-023 ReadMem=0 SHALL hold DataOut at its last value and drive ReadValid=0.
REQ-024 Any request in READY with DataAddress >= DEPTH: write dropped, memory unchanged; on a read, DataOut loads 0 and ReadValid=1; AddrErr=1 for one cycle.
REQ-025 AddrErr SHALL NOT assert for an out-of-range address when neither ReadMem nor WriteMem is high.
REQ-026 WinData word k SHALL update on the same edge as any write (or clear) to address k < WIN; it is visible in the cycle after that edge.
REQ-027 Back-to-back requests every cycle SHALL be accepted with no bubbles; throughput is one read and/or write per cycle.
REQ-028 When DEPTH = 2**ADDR_W, AddrErr SHALL be constant 0.

Reset
REQ-029 ResetN=0 on an edge SHALL set: state CLEAR, clear pointer 0, DataOut 0, ReadValid 0, AddrErr 0, Busy 1, WinData all 0.
REQ-030 ResetN=0 during CLEAR or READY SHALL abort the current activity; the sweep restarts from address 0 after ResetN rises.
REQ-031 While ResetN=0, requests SHALL be ignored and memory SHALL NOT be written except by the clear sweep.

Verification
REQ-032 Defaults; ResetN low 2 cycles, then high -> Busy=1 for exactly 256 cycles; reads of 0x00, 0x7F, 0xFF return 0x00.
REQ-033 READY: write 0xA5 to 0x02, then read 0x02 next cycle -> DataOut=0xA5, ReadValid=1 one cycle later; WinData[23:16]=0xA5.
REQ-034 Read+write same cycle to 0x10 with DataIn=0x3C, old value 0x11 -> DataOut=0x3C next cycle; a later read returns 0x3C.
REQ-035 DEPTH=200: write 0x55 to 0xC8, then read 0xC8 -> AddrErr pulses each time, DataOut=0x00, ReadValid=1 on the read; word 0 unchanged (no aliasing).
REQ-036 Write 0x77 to 0x01, assert ResetN low for 1 cycle at cycle 100 of a later sweep, then release -> Busy stays high 256 cycles after release; read 0x01 returns 0x00.
REQ-037 DATA_W=16, ADDR_W=4, WIN=2: writes to addresses 0..15 every cycle, then reads every cycle -> zero bubbles, each ReadValid carries the matching 16-bit data, WinData = {word1, word0}.
